// File: rtl/ball_physics_if.sv
// Signal bundle between the projectile engine and its neighbours:
// button and tilt come in from the accelerometer side, ball position,
// phase and the physics strobe go out to the renderer.
interface ball_physics_if;
  logic               btn;
  logic signed [15:0] ax;
  logic signed [15:0] ay;
  logic [9:0]         ball_x;
  logic [9:0]         ball_y;
  logic [1:0]         state;
  logic               tick;

  modport master (output btn, ax, ay, input ball_x, ball_y, state, tick);
  modport slave  (input btn, ax, ay, output ball_x, ball_y, state, tick);
endinterface

// File: rtl/ball_physics.sv
// Fixed-point projectile engine. Holding the button charges a launch
// velocity from tilt; releasing it flies the ball under gravity with
// damped bounces off the walls, ceiling and floor until it comes to rest.
module ball_physics #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BALL_R     = 5,
  parameter int START_X    = 100,
  parameter int START_Y    = 400,
  parameter int TICK_DIV   = 25000,
  parameter int POS_FRAC   = 4,
  parameter int VEL_W      = 12,
  parameter int VMAX       = 1000,
  parameter int ACC_SHIFT  = 4,
  parameter int GRAVITY    = 2,
  parameter int DAMP_SHIFT = 2,
  parameter int REST_V     = 8
) (
  input logic           clk,
  input logic           rst,
  ball_physics_if.slave bus
);

  // Position width, candidate width (two guard bits so overshoot past
  // either edge stays representable), and a sum width wide enough for
  // velocity plus a full tilt step before saturation.
  localparam int PW    = 10 + POS_FRAC;
  localparam int CW    = PW + 2;
  localparam int SW    = ((VEL_W > 16) ? VEL_W : 16) + 2;
  localparam int CNT_W = $clog2(TICK_DIV);

  localparam int LIM_L  = BALL_R;
  localparam int LIM_HX = SCREEN_W - 1 - BALL_R;
  localparam int LIM_HY = SCREEN_H - 1 - BALL_R;

  localparam logic [PW-1:0] PX_START = PW'(START_X << POS_FRAC);
  localparam logic [PW-1:0] PY_START = PW'(START_Y << POS_FRAC);
  localparam logic [PW-1:0] PX_LO    = PW'(LIM_L << POS_FRAC);
  localparam logic [PW-1:0] PX_HI    = PW'(LIM_HX << POS_FRAC);
  localparam logic [PW-1:0] PY_LO    = PW'(LIM_L << POS_FRAC);
  localparam logic [PW-1:0] PY_HI    = PW'(LIM_HY << POS_FRAC);

  localparam logic signed [CW-1:0]    CL_L   = CW'(LIM_L);
  localparam logic signed [CW-1:0]    CL_HX  = CW'(LIM_HX);
  localparam logic signed [CW-1:0]    CL_HY  = CW'(LIM_HY);
  localparam logic signed [SW-1:0]    VMAX_S = SW'(VMAX);
  localparam logic signed [SW-1:0]    GRAV_S = SW'(GRAVITY);
  localparam logic signed [VEL_W-1:0] VMAX_V = VEL_W'(VMAX);
  localparam logic signed [VEL_W-1:0] REST_S = VEL_W'(REST_V);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    FLIGHT = 2'd2,
    REST   = 2'd3
  } state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     tick_q;
  logic                     btn_prev;
  logic                     armed;
  logic [PW-1:0]            px;
  logic [PW-1:0]            py;
  logic signed [VEL_W-1:0]  vx;
  logic signed [VEL_W-1:0]  vy;
  logic [9:0]               ball_x_q;
  logic [9:0]               ball_y_q;

  // Clip a widened velocity sum back into +/-VMAX.
  function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [SW-1:0] v);
    logic signed [VEL_W-1:0] r;
    if (v > VMAX_S)       r = VMAX_V;
    else if (v < -VMAX_S) r = -VMAX_V;
    else                  r = v[VEL_W-1:0];
    return r;
  endfunction

  // Reverse a velocity component and shed a fraction of it.
  function automatic logic signed [VEL_W-1:0] damp_vel(input logic signed [VEL_W-1:0] v);
    return -(v - (v >>> DAMP_SHIFT));
  endfunction

  // A press only counts once the button has been seen released since
  // reset, so a button held through reset release is not a launch.
  logic btn_rise;
  assign btn_rise = bus.btn & ~btn_prev & armed;

  logic signed [15:0]      ax_step;
  logic signed [15:0]      ay_step;
  logic signed [SW-1:0]    ax_ext;
  logic signed [SW-1:0]    ay_ext;
  logic signed [SW-1:0]    vx_ext;
  logic signed [SW-1:0]    vy_ext;
  logic signed [VEL_W-1:0] vx_charge;
  logic signed [VEL_W-1:0] vy_charge;
  logic signed [VEL_W-1:0] vy_grav;
  logic signed [VEL_W-1:0] vx_damp;
  logic signed [VEL_W-1:0] vy_damp;

  assign ax_step   = $signed(bus.ax) >>> ACC_SHIFT;
  assign ay_step   = $signed(bus.ay) >>> ACC_SHIFT;
  assign ax_ext    = {{(SW-16){ax_step[15]}}, ax_step};
  assign ay_ext    = {{(SW-16){ay_step[15]}}, ay_step};
  assign vx_ext    = {{(SW-VEL_W){vx[VEL_W-1]}}, vx};
  assign vy_ext    = {{(SW-VEL_W){vy[VEL_W-1]}}, vy};
  assign vx_charge = sat_vel(vx_ext + ax_ext);
  assign vy_charge = sat_vel(vy_ext - ay_ext);
  assign vy_grav   = sat_vel(vy_ext + GRAV_S);
  assign vx_damp   = damp_vel(vx);
  assign vy_damp   = damp_vel(vy);

  logic signed [CW-1:0] cand_x;
  logic signed [CW-1:0] cand_y;
  logic signed [CW-1:0] cand_xi;
  logic signed [CW-1:0] cand_yi;
  logic                 x_lo;
  logic                 x_hi;
  logic                 y_lo;
  logic                 y_hi;
  logic                 rest_hit;

  assign cand_x   = $signed({2'b00, px}) + $signed({{(CW-VEL_W){vx[VEL_W-1]}}, vx});
  assign cand_y   = $signed({2'b00, py}) + $signed({{(CW-VEL_W){vy[VEL_W-1]}}, vy});
  assign cand_xi  = cand_x >>> POS_FRAC;
  assign cand_yi  = cand_y >>> POS_FRAC;
  assign x_lo     = (cand_xi <= CL_L);
  assign x_hi     = (cand_xi >= CL_HX);
  assign y_lo     = (cand_yi <= CL_L);
  assign y_hi     = (cand_yi >= CL_HY);
  assign rest_hit = y_hi && (vy_damp < REST_S) && (vy_damp > -REST_S);

  logic [PW-1:0]           px_next;
  logic [PW-1:0]           py_next;
  logic signed [VEL_W-1:0] vx_next;
  logic signed [VEL_W-1:0] vy_next;

  // One flight step per axis: move, or clamp to the edge and bounce; the
  // vertical axis only feels gravity on ticks where it does not bounce.
  always_comb begin
    px_next = cand_x[PW-1:0];
    vx_next = vx;
    py_next = cand_y[PW-1:0];
    vy_next = vy_grav;
    if (x_lo) begin
      px_next = PX_LO;
      vx_next = vx_damp;
    end else if (x_hi) begin
      px_next = PX_HI;
      vx_next = vx_damp;
    end
    if (y_lo) begin
      py_next = PY_LO;
      vy_next = vy_damp;
    end else if (y_hi) begin
      py_next = PY_HI;
      vy_next = vy_damp;
    end
  end

  // Tick divider, button edge tracking, launch/flight state machine and
  // the registered position outputs, all advancing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      btn_prev <= 1'b0;
      armed    <= 1'b0;
      px       <= PX_START;
      py       <= PY_START;
      vx       <= '0;
      vy       <= '0;
      ball_x_q <= 10'(START_X);
      ball_y_q <= 10'(START_Y);
    end else begin
      cnt_q    <= (cnt_q == CNT_W'(TICK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
      tick_q   <= (cnt_q == CNT_W'(TICK_DIV - 2));
      btn_prev <= bus.btn;
      if (!bus.btn) armed <= 1'b1;
      ball_x_q <= px[PW-1:POS_FRAC];
      ball_y_q <= py[PW-1:POS_FRAC];
      case (state_q)
        IDLE: begin
          px <= PX_START;
          py <= PY_START;
          vx <= '0;
          vy <= '0;
          if (btn_rise) state_q <= CHARGE;
        end
        CHARGE: begin
          if (!bus.btn) begin
            state_q <= FLIGHT;
          end else if (tick_q) begin
            vx <= vx_charge;
            vy <= vy_charge;
          end
        end
        FLIGHT: begin
          if (tick_q) begin
            px <= px_next;
            py <= py_next;
            if (rest_hit) begin
              vx      <= '0;
              vy      <= '0;
              state_q <= REST;
            end else begin
              vx <= vx_next;
              vy <= vy_next;
            end
          end
        end
        REST: begin
          vx <= '0;
          vy <= '0;
          if (btn_rise) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ball_x = ball_x_q;
  assign bus.ball_y = ball_y_q;
  assign bus.state  = state_q;
  assign bus.tick   = tick_q;

endmodule

// File: doc/ball_physics.md
# ball_physics

Fixed-point projectile engine for the shot simulator. It sits between the accelerometer front end and the VGA renderer. While the shot button is held, the block charges a launch velocity from tilt (`ax`, `ay`). On release it flies the ball under gravity with damped wall, ceiling and floor bounces, then parks it at rest. It generalises the fixed-step bounce mover with parametrised screen size, tick rate, fixed-point precision, gravity, damping and a launch/charge state machine.

## Interface
- `SCREEN_W`, 640: visible width in px.
- `SCREEN_H`, 480: visible height in px.
- `BALL_R`, 5: ball radius in px; sets the bounce limits.
- `START_X`, 100; `START_Y`, 400: launch position in px.
- `TICK_DIV`, 25000: clk cycles per physics step (min 2).
- `POS_FRAC`, 4: fractional bits of position and velocity.
- `VEL_W`, 12: signed velocity width.
- `VMAX`, 1000: velocity saturation magnitude (< 2^(VEL_W-1)).
- `ACC_SHIFT`, 4: arithmetic right shift applied to `ax`/`ay` per charge tick.
- `GRAVITY`, 2: added to vy every flight tick (fractional units).
- `DAMP_SHIFT`, 2: a bounce removes |v|>>DAMP_SHIFT.
- `REST_V`, 8: a floor bounce with |vy| below this ends flight.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: synchronous, active-low reset.
- `btn` in 1: shot button, level; debounced and synchronised upstream.
- `ax` in 16: signed accelerometer X, 1 LSB = 1 mg.
- `ay` in 16: signed accelerometer Y, 1 LSB = 1 mg.
- `ball_x` out 10: ball centre X, integer px, registered.
- `ball_y` out 10: ball centre Y, integer px, registered (down positive).
- `state` out 2: 0 IDLE, 1 CHARGE, 2 FLIGHT, 3 REST.
- `tick` out 1: one-cycle physics-step strobe.

## Operation
- **Tick counter:** free-running 0..TICK_DIV-1. `tick`=1 on the cycle the count equals TICK_DIV-1. The counter runs in every state.
- **Registers:** px/py are unsigned, 10+POS_FRAC bits. vx/vy are signed, VEL_W bits. Every velocity add saturates to ±VMAX.
- **State transitions** are evaluated every clk. Physics updates happen only when `tick`=1.
  - IDLE: px,py = START; vx,vy = 0. A btn rising edge (btn=1, previous btn=0) moves to CHARGE.
  - CHARGE, btn=1, on tick: vx += ax>>>ACC_SHIFT; vy -= ay>>>ACC_SHIFT. Positive ay launches upward.
  - CHARGE, btn=0: move to FLIGHT. No accumulation on that cycle, even if `tick`=1.
  - FLIGHT, on tick: the candidate position is p+v, computed signed with 2 guard bits. Then vy += GRAVITY. btn is ignored.
  - REST: position holds and v=0. A btn rising edge moves to IDLE.
- **Bounce,** with limits L=BALL_R and H=SCREEN_W-1-BALL_R (X) or SCREEN_H-1-BALL_R (Y), in integer px:
  - If the candidate is ≤ L or ≥ H, clamp the position to that limit.
  - Set v = -(v - (v>>>DAMP_SHIFT)).
  - Gravity is not applied to vy on a Y-bounce tick.
- **Corner:** X and Y bounces apply in the same tick.
- **Floor rest:** if a Y bounce is at H_y and the post-damp |vy| < REST_V, then vx=vy=0, py is clamped, and the state moves to REST.
- **Outputs:** `ball_x`/`ball_y` are registered from px/py >> POS_FRAC and update the cycle after the register update. The values always lie within [BALL_R, limit].

## Timing
- **Reset** (rst=0 at a posedge): state=IDLE, counter=0, tick=0, ball_x=START_X, ball_y=START_Y, v=0, previous btn=0. Reset overrides everything, including mid-FLIGHT.
- **Tick period:** exactly TICK_DIV cycles. The first tick comes TICK_DIV cycles after reset release.
- **Latency:**
  - btn edge to `state` change: 1 cycle.
  - Tick to `ball_x`/`ball_y` change: 2 cycles.
- **btn held through reset release:** not an edge; the state stays in IDLE until btn drops and rises again.

## Test plan
- **Reset:** hold rst=0 for 3 cycles, TICK_DIV=4 -> ball=(100,400), state=0, tick pulses every 4 cycles after release.
- **Charge:** rising edge, ax=+64, ay=+64, ACC_SHIFT=4, hold 10 ticks -> vx=+40, vy=-40. Release -> state=2 next cycle, no extra accumulation.
- **Flight:** vx=32, vy=0, GRAVITY=2, POS_FRAC=4 -> ball_x advances 2 px/tick; vy = 2, 4, 6… on successive ticks.
- **Wall bounce:** ball at x=633, vx=+64 -> ball_x=634, vx=-48. Corner case with vy also bouncing -> both components negated and damped in the same tick.
- **Saturation/rest:** ax=32767 held 100 ticks -> vx=+1000. Floor bounce with |vy|=6 -> state=3, ball_y=474, v=0. btn edge -> state=0, ball=(100,400).
- **Reset mid-flight:** rst=0 during FLIGHT -> IDLE and start position on the next edge, no further motion.
